rf_debug_arbiter: RTL and testbench
===================================

# rf_debug_arbiter

Shares the CPU register file's write port and second read port between the pipeline and a debug requester. The debug requester is a bench, a switch/HEX inspector, or a future JTAG bridge. The block sits between `cpu` and `rf_inst`. The CPU keeps priority; debug accesses are slotted into idle cycles. A forced one-cycle pipeline stall guarantees forward progress after `MAX_WAIT` blocked cycles.

## Interface
- `MAX_WAIT`, default 8: blocked cycles tolerated in WAIT before a stall is forced; legal range 1..255.
- `clk`  in  1  CPU clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cpu_rf_re`  in  1  pipeline uses read port 2 this cycle.
- `cpu_raddr2`  in  5  pipeline rs2 address.
- `cpu_we`  in  1  pipeline writeback enable.
- `cpu_waddr`  in  5  pipeline writeback address.
- `cpu_wdata`  in  32  pipeline writeback data.
- `cpu_stall`  out  1  freeze pipeline this cycle.
- `rf_raddr2`  out  5  register file read port 2 address.
- `rf_rdata2`  in  32  register file read port 2 data (combinational read).
- `rf_we`  out  1  register file write enable.
- `rf_waddr`  out  5  register file write address.
- `rf_wdata`  out  32  register file write data.
- `dbg_req_valid`  in  1  debug request offered.
- `dbg_req_ready`  out  1  request accepted when high with valid.
- `dbg_req_write`  in  1  1 = write, 0 = read.
- `dbg_req_addr`  in  5  target register.
- `dbg_req_wdata`  in  32  write data.
- `dbg_rsp_valid`  out  1  response available.
- `dbg_rsp_ready`  in  1  response consumed.
- `dbg_rsp_rdata`  out  32  read data (reads), or the written data (writes).
- `stall_count`  out  16  saturating count of forced stalls.

## Operation
- The FSM has four states: IDLE, WAIT, STALL, RESP. Reset state is IDLE.
- **IDLE:**
  - `dbg_req_ready`=1.
  - On `dbg_req_valid`, latch write/addr/wdata into a one-entry buffer, clear the wait counter, and go to WAIT.
- **WAIT:** the slot is free when `cpu_rf_re`=0 (read) or `cpu_we`=0 (write).
  - Slot free: the arbiter owns the port this cycle.
    - Read: `rf_raddr2`=buffered addr, and `rf_rdata2` is captured into the response register.
    - Write: `rf_we`=1, `rf_waddr`/`rf_wdata` come from the buffer, and the response register is loaded with the wdata.
    - Then go to RESP.
  - Slot busy: the CPU is passed through and the wait counter increments.
    - On the `MAX_WAIT`-th busy cycle, go to STALL.
- **STALL:**
  - `cpu_stall`=1 for exactly this cycle.
  - The arbiter owns the port unconditionally and performs the access as above.
  - `cpu_rf_re`/`cpu_we` are ignored this cycle. The CPU contract is that it holds its pipeline and re-presents the same writeback next cycle, so no CPU write is lost.
  - `stall_count` increments, saturating at 16'hFFFF. Then go to RESP.
- **RESP:**
  - `dbg_rsp_valid`=1 and `dbg_rsp_rdata` is held stable.
  - On `dbg_rsp_ready`, go to IDLE.
- **Ownership:** whenever the arbiter does not own a port, that port passes through from the CPU combinationally.
- **x0:** a debug write to addr 0 completes normally with a response (rdata = wdata) but keeps `rf_we`=0. Reads of x0 return whatever `rf_rdata2` supplies.
- **Single outstanding request:** `dbg_req_ready`=0 in WAIT, STALL and RESP.
- **Reset mid-operation:** `rst` high in any state returns to IDLE next edge. The buffered request is discarded and no response is issued. `stall_count` clears to 0.

## Timing
- **Outputs while `rst`=1:**
  - `dbg_req_ready`=0, `dbg_rsp_valid`=0, `cpu_stall`=0, `rf_we`=0.
  - `rf_raddr2`/`rf_waddr`/`rf_wdata` = CPU values.
- **Outputs after reset:** `stall_count`=0 and `dbg_rsp_rdata`=0 in the first cycle after reset.
- **Latency:** request accepted at edge T.
  - Free slot: access happens in cycle T+1 and `dbg_rsp_valid` rises at T+2.
  - Fully blocked: STALL falls in cycle T+1+MAX_WAIT and `dbg_rsp_valid` rises at T+2+MAX_WAIT.
- **Response hold:** `dbg_rsp_valid` with `dbg_rsp_ready` tied high lasts exactly one cycle. The next request can be accepted in the cycle after RESP exits.
- **Write timing:** a debug write becomes visible to a CPU read on the cycle after the `rf_we` pulse, per register file write timing.
- **Simultaneous events:** a slot that frees in the same cycle the counter would reach `MAX_WAIT` takes the free-slot path. No stall occurs and `stall_count` is unchanged.
- **`cpu_stall` source:** the signal is a decode of the registered state, with no combinational path from CPU inputs.

## Test plan
- **Free-slot read:** preload x8=1.
  - Stimulus: debug read addr 8 with `cpu_rf_re`=0.
  - Required: `dbg_rsp_rdata`=1 two cycles after accept, and `cpu_stall` never asserted.
- **Free-slot write:** debug write x21=6 with `cpu_we`=0.
  - Required: a single `rf_we` pulse to addr 21. A following debug read returns 6.
- **Forced stall:** `MAX_WAIT`=8, `cpu_rf_re` held 1, debug read x9 (=2).
  - Required: `cpu_stall` high exactly one cycle at T+9, `dbg_rsp_valid` at T+10, rdata=2, `stall_count`=1.
- **x0 write:** debug write addr 0 data 32'hDEADBEEF.
  - Required: `rf_we` stays 0 and the response returns rdata 32'hDEADBEEF.
- **Backpressure then reset:**
  - Hold `dbg_rsp_ready`=0 for 5 cycles. Required: rsp valid and data stable, `dbg_req_ready`=0.
  - Assert `rst` during RESP. Required: `dbg_rsp_valid`=0 next cycle, `dbg_req_ready`=1 after release, `stall_count`=0.
- **Coincident slot-free:** the slot frees on the 8th blocked cycle. Required: no stall, and the response arrives on the free-slot path.

Source files
------------

// File: rtl/rf_debug_arbiter.sv
// rtl/rf_debug_arbiter.sv - register file port arbiter between CPU pipeline and debug requester
//
// Purpose: shares the register file write port and read port 2 between the
// CPU pipeline (priority) and a single-outstanding debug request channel.
// Debug accesses use idle port cycles; after MAX_WAIT blocked cycles a
// one-cycle pipeline stall is forced so the debug access always completes.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   cpu_*               pipeline read-port-2 / writeback requests
//   cpu_stall           one-cycle pipeline freeze (decoded from state)
//   rf_*                register file read port 2 and write port
//   dbg_req_*           debug request channel (valid/ready)
//   dbg_rsp_*           debug response channel (valid/ready)
//   stall_count         saturating count of forced stalls
module rf_debug_arbiter #(
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_rf_re,
  input  logic [4:0]  cpu_raddr2,
  input  logic        cpu_we,
  input  logic [4:0]  cpu_waddr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_stall,
  output logic [4:0]  rf_raddr2,
  input  logic [31:0] rf_rdata2,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  input  logic        dbg_req_valid,
  output logic        dbg_req_ready,
  input  logic        dbg_req_write,
  input  logic [4:0]  dbg_req_addr,
  input  logic [31:0] dbg_req_wdata,
  output logic        dbg_rsp_valid,
  input  logic        dbg_rsp_ready,
  output logic [31:0] dbg_rsp_rdata,
  output logic [15:0] stall_count
);

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_STALL,
    S_RESP
  } state_t;

  state_t      state_q;
  logic        buf_write_q;
  logic [4:0]  buf_addr_q;
  logic [31:0] buf_wdata_q;
  logic [7:0]  wait_cnt_q;
  logic [7:0]  wait_cnt_d;
  logic [31:0] rsp_q;
  logic [15:0] stall_cnt_q;

  logic slot_free;
  logic access;
  logic own_rd;
  logic own_wr;

  // The slot only depends on the port the buffered request needs.
  assign slot_free  = buf_write_q ? !cpu_we : !cpu_rf_re;
  assign access     = !rst && ((state_q == S_STALL) || ((state_q == S_WAIT) && slot_free));
  assign own_rd     = access && !buf_write_q;
  assign own_wr     = access && buf_write_q;
  assign wait_cnt_d = wait_cnt_q + 8'd1;

  // Unowned ports pass through from the CPU; x0 writes are suppressed.
  assign rf_raddr2 = own_rd ? buf_addr_q  : cpu_raddr2;
  assign rf_waddr  = own_wr ? buf_addr_q  : cpu_waddr;
  assign rf_wdata  = own_wr ? buf_wdata_q : cpu_wdata;
  assign rf_we     = own_wr ? (buf_addr_q != 5'd0) : (cpu_we && !rst);

  assign cpu_stall     = !rst && (state_q == S_STALL);
  assign dbg_req_ready = !rst && (state_q == S_IDLE);
  assign dbg_rsp_valid = !rst && (state_q == S_RESP);
  assign dbg_rsp_rdata = rsp_q;
  assign stall_count   = stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      buf_write_q <= 1'b0;
      buf_addr_q  <= 5'd0;
      buf_wdata_q <= 32'd0;
      wait_cnt_q  <= 8'd0;
      rsp_q       <= 32'd0;
      stall_cnt_q <= 16'd0;
    end else begin
      if (access) begin
        rsp_q <= buf_write_q ? buf_wdata_q : rf_rdata2;
      end
      case (state_q)
        S_IDLE: begin
          if (dbg_req_valid) begin
            buf_write_q <= dbg_req_write;
            buf_addr_q  <= dbg_req_addr;
            buf_wdata_q <= dbg_req_wdata;
            wait_cnt_q  <= 8'd0;
            state_q     <= S_WAIT;
          end
        end
        S_WAIT: begin
          // A free slot wins even on the cycle the counter would expire.
          if (slot_free) begin
            state_q <= S_RESP;
          end else if (wait_cnt_d == MAX_WAIT_C) begin
            state_q <= S_STALL;
          end else begin
            wait_cnt_q <= wait_cnt_d;
          end
        end
        S_STALL: begin
          if (stall_cnt_q != 16'hFFFF) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
          end
          state_q <= S_RESP;
        end
        S_RESP: begin
          if (dbg_rsp_ready) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rf_debug_arbiter.sv
// tb/tb_rf_debug_arbiter.sv - self-checking bench for rf_debug_arbiter
module tb_rf_debug_arbiter;

  localparam int MW = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_rf_re;
  logic [4:0]  cpu_raddr2;
  logic        cpu_we;
  logic [4:0]  cpu_waddr;
  logic [31:0] cpu_wdata;
  logic        cpu_stall;
  logic [4:0]  rf_raddr2;
  logic [31:0] rf_rdata2;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        dbg_req_valid;
  logic        dbg_req_ready;
  logic        dbg_req_write;
  logic [4:0]  dbg_req_addr;
  logic [31:0] dbg_req_wdata;
  logic        dbg_rsp_valid;
  logic        dbg_rsp_ready;
  logic [31:0] dbg_rsp_rdata;
  logic [15:0] stall_count;

  always #5 clk = ~clk;

  rf_debug_arbiter #(.MAX_WAIT(MW)) dut (
    .clk           (clk),
    .rst           (rst),
    .cpu_rf_re     (cpu_rf_re),
    .cpu_raddr2    (cpu_raddr2),
    .cpu_we        (cpu_we),
    .cpu_waddr     (cpu_waddr),
    .cpu_wdata     (cpu_wdata),
    .cpu_stall     (cpu_stall),
    .rf_raddr2     (rf_raddr2),
    .rf_rdata2     (rf_rdata2),
    .rf_we         (rf_we),
    .rf_waddr      (rf_waddr),
    .rf_wdata      (rf_wdata),
    .dbg_req_valid (dbg_req_valid),
    .dbg_req_ready (dbg_req_ready),
    .dbg_req_write (dbg_req_write),
    .dbg_req_addr  (dbg_req_addr),
    .dbg_req_wdata (dbg_req_wdata),
    .dbg_rsp_valid (dbg_rsp_valid),
    .dbg_rsp_ready (dbg_rsp_ready),
    .dbg_rsp_rdata (dbg_rsp_rdata),
    .stall_count   (stall_count)
  );

  // Register file driven by the DUT; reference contents kept in m_mem.
  logic [31:0] rf_mem [32];
  logic [31:0] m_mem  [32];
  logic        init_en;

  assign rf_rdata2 = rf_mem[rf_raddr2];

  always @(posedge clk) begin
    if (init_en) begin
      for (int k = 0; k < 32; k++) rf_mem[k] <= m_mem[k];
    end else if (rf_we) begin
      rf_mem[rf_waddr] <= rf_wdata;
    end
  end

  int checks = 0;
  int errors = 0;
  int m_stalls = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // CPU writes stay in x24..x31 so directed targets keep their values.
  task automatic drive_cpu_random();
    cpu_rf_re  = 1'($urandom);
    cpu_raddr2 = 5'($urandom);
    cpu_we     = 1'($urandom);
    cpu_waddr  = 5'($urandom_range(24, 31));
    cpu_wdata  = $urandom;
  endtask

  task automatic check_ports(input string tag, input bit e_stall, input bit e_rq, input bit e_rv,
                             input bit own_rd, input bit own_wr,
                             input logic [4:0] a, input logic [31:0] wd);
    logic e_we;
    e_we = rst ? 1'b0 : (own_wr ? (a != 5'd0) : cpu_we);
    chk({tag, ".cpu_stall"}, 32'(cpu_stall), 32'(e_stall));
    chk({tag, ".req_ready"}, 32'(dbg_req_ready), 32'(e_rq));
    chk({tag, ".rsp_valid"}, 32'(dbg_rsp_valid), 32'(e_rv));
    chk({tag, ".rf_we"}, 32'(rf_we), 32'(e_we));
    chk({tag, ".rf_raddr2"}, 32'(rf_raddr2), 32'(own_rd ? a : cpu_raddr2));
    chk({tag, ".rf_waddr"}, 32'(rf_waddr), 32'(own_wr ? a : cpu_waddr));
    chk({tag, ".rf_wdata"}, rf_wdata, own_wr ? wd : cpu_wdata);
  endtask

  task automatic model_commit(input bit dbg_wr, input logic [4:0] a, input logic [31:0] wd);
    if (dbg_wr) begin
      if (a != 5'd0) m_mem[a] = wd;
    end else if (cpu_we && !rst) begin
      m_mem[cpu_waddr] = cpu_wdata;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // free_at: first free slot cycle after accept (1..MW), or 0 for fully blocked.
  task automatic do_req(input bit wr, input logic [4:0] a, input logic [31:0] wd,
                        input int free_at, input int hold, input bit rst_in_resp,
                        input string tag);
    logic [31:0] exp_rsp;
    int acc;
    bit stall;
    exp_rsp = 32'd0;
    acc   = (free_at >= 1 && free_at <= MW) ? free_at : MW + 1;
    stall = (acc == MW + 1);

    drive_cpu_random();
    dbg_req_valid = 1'b1;
    dbg_req_write = wr;
    dbg_req_addr  = a;
    dbg_req_wdata = wd;
    dbg_rsp_ready = 1'($urandom);
    @(negedge clk);
    check_ports({tag, ".acc"}, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, a, wd);
    model_commit(1'b0, a, wd);
    tick();

    for (int i = 1; i <= acc; i++) begin
      drive_cpu_random();
      dbg_req_valid = 1'($urandom);
      dbg_req_write = 1'($urandom);
      dbg_req_addr  = 5'($urandom);
      dbg_req_wdata = $urandom;
      if (i <= MW) begin
        if (wr) cpu_we = (i < acc);
        else    cpu_rf_re = (i < acc);
      end
      @(negedge clk);
      if (i == acc) exp_rsp = wr ? wd : m_mem[a];
      check_ports({tag, (i == acc) ? ".access" : ".wait"}, (i == acc) && stall, 1'b0, 1'b0,
                  (i == acc) && !wr, (i == acc) && wr, a, wd);
      model_commit((i == acc) && wr, a, wd);
      tick();
    end
    if (stall && m_stalls < 65535) m_stalls++;

    for (int h = 0; h <= hold; h++) begin
      drive_cpu_random();
      dbg_req_valid = 1'($urandom);
      dbg_rsp_ready = (h == hold) && !rst_in_resp;
      rst           = (h == hold) && rst_in_resp;
      @(negedge clk);
      if (rst) begin
        check_ports({tag, ".rst"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, a, wd);
      end else begin
        check_ports({tag, ".resp"}, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, a, wd);
        chk({tag, ".rsp_rdata"}, dbg_rsp_rdata, exp_rsp);
        chk({tag, ".stall_count"}, 32'(stall_count), 32'(m_stalls));
      end
      model_commit(1'b0, a, wd);
      tick();
    end

    if (rst_in_resp) begin
      rst = 1'b0;
      m_stalls = 0;
    end
    drive_cpu_random();
    dbg_req_valid = 1'b0;
    dbg_rsp_ready = 1'b0;
    @(negedge clk);
    check_ports({tag, ".idle"}, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, a, wd);
    chk({tag, ".idle_stall_count"}, 32'(stall_count), 32'(m_stalls));
    if (rst_in_resp) chk({tag, ".rst_rsp_rdata"}, dbg_rsp_rdata, 32'd0);
    model_commit(1'b0, a, wd);
    tick();
  endtask

  initial begin
    for (int k = 0; k < 32; k++) m_mem[k] = (k == 0) ? 32'd0 : $urandom;
    m_mem[8] = 32'd1;
    m_mem[9] = 32'd2;
    init_en = 1'b1;
    rst = 1'b1;
    dbg_req_valid = 1'b0;
    dbg_req_write = 1'b0;
    dbg_req_addr  = 5'd0;
    dbg_req_wdata = 32'd0;
    dbg_rsp_ready = 1'b0;
    drive_cpu_random();
    tick();
    tick();
    init_en = 1'b0;
    drive_cpu_random();
    @(negedge clk);
    check_ports("in_rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    model_commit(1'b0, 5'd0, 32'd0);
    tick();
    rst = 1'b0;
    drive_cpu_random();
    @(negedge clk);
    check_ports("post_rst", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    chk("post_rst.stall_count", 32'(stall_count), 32'd0);
    chk("post_rst.rsp_rdata", dbg_rsp_rdata, 32'd0);
    model_commit(1'b0, 5'd0, 32'd0);
    tick();

    do_req(1'b0, 5'd8,  32'd0,          1, 0, 1'b0, "free_rd");
    do_req(1'b1, 5'd21, 32'd6,          1, 0, 1'b0, "free_wr");
    do_req(1'b0, 5'd21, 32'd0,          1, 0, 1'b0, "rd_back");
    do_req(1'b0, 5'd9,  32'd0,          0, 0, 1'b0, "stall_rd");
    do_req(1'b1, 5'd0,  32'hDEADBEEF,   3, 0, 1'b0, "x0_wr");
    do_req(1'b1, 5'd22, 32'h1234_5678,  0, 1, 1'b0, "stall_wr");
    do_req(1'b0, 5'd22, 32'd0,          2, 0, 1'b0, "rd_stall_wr");
    do_req(1'b0, 5'd8,  32'd0,          2, 5, 1'b1, "bp_rst");
    do_req(1'b0, 5'd9,  32'd0,         MW, 0, 1'b0, "coinc");
    do_req(1'b1, 5'd9,  32'd7,         MW, 0, 1'b0, "coinc_wr");

    for (int n = 0; n < 40; n++) begin
      do_req(1'($urandom), 5'($urandom), $urandom, $urandom_range(0, MW),
             $urandom_range(0, 3), $urandom_range(0, 15) == 0, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
